cp0_unit: RTL

//  Coprocessor-0 register file that receives the control unit's exception and CP0 signals.

---
 rtl/cp0_unit_pkg.sv | 30 +++
 rtl/cp0_unit_if.sv | 27 ++
 rtl/cp0_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, SR/Cause bit positions.
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int unsigned SR_IE         = 0;
  localparam int unsigned SR_EXL        = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD      = 31;

  // Return address recorded for a faulting instruction; delay-slot faults resume at the branch.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Control-unit <-> CP0 signal bundle; master is the control unit, slave is CP0.
interface cp0_unit_if #(
  parameter int unsigned HWINT_W = 6
);
  logic [4:0]         A1;
  logic [4:0]         A2;
  logic [31:0]        Din;
  logic [31:0]        PC;
  logic               BDIn;
  logic [4:0]         ExcCodeIn;
  logic [HWINT_W-1:0] HWInt;
  logic               En;
  logic               EXLClr;
  logic               Req;
  logic [31:0]        EPCOut;
  logic [31:0]        Dout;

  modport master (
    output A1, A2, Din, PC, BDIn, ExcCodeIn, HWInt, En, EXLClr,
    input  Req, EPCOut, Dout
  );

  modport slave (
    input  A1, A2, Din, PC, BDIn, ExcCodeIn, HWInt, En, EXLClr,
    output Req, EPCOut, Dout
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers plus interrupt-vs-exception arbitration.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_5C0A,
  parameter int unsigned HWINT_W    = 6
) (
  input logic        clk,
  input logic        reset,
  cp0_unit_if.slave  bus
);

  logic               ie;
  logic               exl;
  logic [HWINT_W-1:0] im;
  logic               bd;
  logic [HWINT_W-1:0] ip;
  logic [4:0]         exc_code;
  logic [31:0]        epc;

  logic               int_req;
  logic               exc_req;
  logic               req;
  logic [31:0]        sr_val;
  logic [31:0]        cause_val;

  // Arbitration: interrupts need IE and an unmasked line; both are blocked while EXL is set.
  always_comb begin
    int_req = ie & ~exl & (|(bus.HWInt & im));
    exc_req = ~exl & (bus.ExcCodeIn != 5'd0);
    req     = reset & (int_req | exc_req);
  end

  // Architectural views of SR and Cause; unimplemented bits read as zero.
  always_comb begin
    sr_val                             = '0;
    sr_val[SR_IM_LSB +: HWINT_W]       = im;
    sr_val[SR_EXL]                     = exl;
    sr_val[SR_IE]                      = ie;
    cause_val                          = '0;
    cause_val[CAUSE_BD]                = bd;
    cause_val[CAUSE_IP_LSB +: HWINT_W] = ip;
    cause_val[CAUSE_EXC_LSB +: 5]      = exc_code;
  end

  // Outputs: mfc0 read mux and EPC with mtc0 bypass so mtc0 EPC ; eret works back-to-back.
  always_comb begin
    bus.Req = req;
    case (bus.A1)
      REG_SR:    bus.Dout = sr_val;
      REG_CAUSE: bus.Dout = cause_val;
      REG_EPC:   bus.Dout = epc;
      REG_PRID:  bus.Dout = PRID_VALUE;
      default:   bus.Dout = '0;
    endcase
    bus.EPCOut = (bus.En && !req && bus.A2 == REG_EPC) ? bus.Din : epc;
  end

  // Register update: reset, else exception entry, else mtc0 then eret (later NBA clears EXL).
  always_ff @(posedge clk) begin
    if (!reset) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bus.BDIn;
        exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc      <= epc_target(bus.PC, bus.BDIn);
      end else begin
        if (bus.En) begin
          case (bus.A2)
            REG_SR: begin
              im  <= bus.Din[SR_IM_LSB +: HWINT_W];
              exl <= bus.Din[SR_EXL];
              ie  <= bus.Din[SR_IE];
            end
            REG_EPC: epc <= bus.Din;
            default: ;
          endcase
        end
        if (bus.EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule
